// File: rtl/count_seq_monitor_pkg.sv
// Shared types and constants for the counter sequence monitor:
// event codes, FSM encoding and event-record sizing.
package count_mon_pkg;

  localparam int EVT_CODE_W = 2;

  typedef enum logic [1:0] {
    EVT_WRAP    = 2'd0,
    EVT_RESTART = 2'd1,
    EVT_SKIP    = 2'd2,
    EVT_HOLD    = 2'd3
  } evt_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  // An event record is {code, sampled value}.
  function automatic int evt_rec_w(input int width);
    return EVT_CODE_W + width;
  endfunction

endpackage

// File: rtl/count_seq_monitor_if.sv
// Observation and event-drain bundle of the counter sequence monitor.
interface count_seq_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] q_in;
  logic             q_valid;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [WIDTH-1:0] evt_value;
  logic [CNT_W-1:0] wrap_count;
  logic [CNT_W-1:0] err_count;
  logic             overflow;
  logic             locked;

  modport master (
    output q_in, q_valid, evt_ready,
    input  evt_valid, evt_code, evt_value, wrap_count, err_count, overflow, locked
  );

  modport slave (
    input  q_in, q_valid, evt_ready,
    output evt_valid, evt_code, evt_value, wrap_count, err_count, overflow, locked
  );
endinterface

// File: rtl/count_seq_monitor_evt_fifo.sv
// Synchronous event FIFO with a registered head that holds its last value
// while empty; a push is accepted when full only if a pop happens alongside.
module evt_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_dout,
  output logic          o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_nxt;
  logic [DW-1:0] w_dout_nxt;

  assign w_empty  = (r_count == (AW+1)'(0));
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop    = ~w_empty & i_ready;
  assign w_push   = i_push & (~o_full | w_pop);
  assign w_rd_nxt = r_rd_ptr + AW'(1);
  assign o_valid  = ~w_empty;
  assign o_dout   = r_dout;

  // Next head: the following entry on pop, the incoming event when it lands first.
  always_comb begin
    w_dout_nxt = r_dout;
    if (w_pop) begin
      if (r_count > (AW+1)'(1)) begin
        w_dout_nxt = r_mem[w_rd_nxt];
      end else if (w_push) begin
        w_dout_nxt = i_din;
      end else begin
        w_dout_nxt = r_dout;
      end
    end else if (w_empty && w_push) begin
      w_dout_nxt = i_din;
    end else begin
      w_dout_nxt = r_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_dout   <= {DW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_dout <= w_dout_nxt;
    end
  end
endmodule

// File: rtl/count_seq_monitor.sv
// Checks an up-counter's output for continuity, classifies each discontinuity
// and queues event records plus saturating wrap/skip tallies.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  count_seq_monitor_if.slave bus
);
  localparam int DW = evt_rec_w(WIDTH);
  localparam logic [WIDTH-1:0] MAX_Q = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] SAT_C = {CNT_W{1'b1}};

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0] r_wrap_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_overflow;
  logic             w_evt_push;
  evt_code_e        w_evt_code;
  logic             w_fifo_full;
  logic             w_fifo_valid;
  logic [DW-1:0]    w_fifo_dout;
  logic             w_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = bus.q_valid ? ST_TRACK : ST_IDLE;
      ST_TRACK: w_state_nxt = ST_TRACK;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // RESTART is tested before HOLD so a repeated zero reads as an upstream reset.
  always_comb begin
    w_evt_push = 1'b0;
    w_evt_code = EVT_WRAP;
    if (bus.q_valid && (r_state == ST_TRACK)) begin
      if ((bus.q_in == r_prev + WIDTH'(1)) && (r_prev != MAX_Q)) begin
        w_evt_push = 1'b0;
      end else if ((r_prev == MAX_Q) && (bus.q_in == {WIDTH{1'b0}})) begin
        w_evt_push = 1'b1;
        w_evt_code = EVT_WRAP;
      end else if (bus.q_in == {WIDTH{1'b0}}) begin
        w_evt_push = 1'b1;
        w_evt_code = EVT_RESTART;
      end else if (bus.q_in == r_prev) begin
        w_evt_push = 1'b1;
        w_evt_code = EVT_HOLD;
      end else begin
        w_evt_push = 1'b1;
        w_evt_code = EVT_SKIP;
      end
    end else begin
      w_evt_push = 1'b0;
    end
  end

  assign w_drop = w_evt_push & w_fifo_full & ~(w_fifo_valid & bus.evt_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev     <= {WIDTH{1'b0}};
      r_wrap_cnt <= {CNT_W{1'b0}};
      r_err_cnt  <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (bus.q_valid) begin
        r_prev <= bus.q_in;
      end
      if (w_evt_push && (w_evt_code == EVT_WRAP) && (r_wrap_cnt != SAT_C)) begin
        r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
      end
      if (w_evt_push && (w_evt_code == EVT_SKIP) && (r_err_cnt != SAT_C)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  evt_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_evt_push),
    .i_din   ({w_evt_code, bus.q_in}),
    .i_ready (bus.evt_ready),
    .o_valid (w_fifo_valid),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full)
  );

  assign bus.evt_valid  = w_fifo_valid;
  assign bus.evt_code   = w_fifo_dout[DW-1 -: 2];
  assign bus.evt_value  = w_fifo_dout[WIDTH-1:0];
  assign bus.wrap_count = r_wrap_cnt;
  assign bus.err_count  = r_err_cnt;
  assign bus.overflow   = r_overflow;
  assign bus.locked     = (r_state == ST_TRACK);
endmodule

// File: doc/count_seq_monitor.md
# count_seq_monitor

Downstream checker for the 4-bit up-counter. It samples the counter's `q` output on every valid cycle and tracks the expected increment sequence. It classifies each discontinuity (wrap, restart, skip) and queues the resulting event records in a small FIFO drained through a valid/ready handshake. It also keeps saturating wrap and error tallies for status readout.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `CNT_W`, 8: width of the `wrap_count` and `err_count` tallies.
- `DEPTH`, 4: event FIFO depth; power of two, minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock domain only.
- `q_in`  in  WIDTH  counter value under observation.
- `q_valid`  in  1  `q_in` is sampled this cycle.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_code`  out  2  head event code.
- `evt_value`  out  WIDTH  `q_in` value that raised the head event.
- `wrap_count`  out  CNT_W  saturating count of WRAP events.
- `err_count`  out  CNT_W  saturating count of SKIP events.
- `overflow`  out  1  sticky; at least one event was dropped.
- `locked`  out  1  state is TRACK.

## Operation
- FSM has two states.
  - IDLE: on the first `q_valid`, capture `q_in` into `prev`, raise no event, and go to TRACK.
  - TRACK: every `q_valid` sample is classified against `prev` using modulo-2^WIDTH arithmetic.
- Classification in TRACK:
  - `q_in == prev+1` and `prev != max`: normal; no event.
  - `prev == max` and `q_in == 0`: WRAP (code 0); `wrap_count` increments.
  - `q_in == 0` and `prev != max`: RESTART (code 1); no tally change; this is the upstream reset-mid-count case.
  - `q_in == prev`: HOLD (code 3); no tally change.
  - Any other value: SKIP (code 2); `err_count` increments.
- After every `q_valid` sample in TRACK, `prev <= q_in`.
- `q_valid` low: no state, tally, or FIFO change.
- Tallies saturate at all-ones and never wrap.
- FIFO behaviour:
  - An event is pushed into the DEPTH-entry FIFO as the pair {code, `q_in`}.
  - A pop occurs when `evt_valid & evt_ready`.
- FIFO full and a new event:
  - With a pop in the same cycle: push and pop both happen and occupancy is unchanged.
  - Without a pop: the new event is dropped, `overflow` sets, and FIFO contents are unchanged. The tallies still update.
- FIFO empty: `evt_ready` is ignored; `evt_code` and `evt_value` are don't-care but must be stable (hold the last head).
- Reset values when `rst` is low: state IDLE, `prev` 0, FIFO empty, `evt_valid` 0, `evt_code` 0, `evt_value` 0, `wrap_count` 0, `err_count` 0, `overflow` 0, `locked` 0.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge. The first sample after release re-enters IDLE→TRACK and raises no event.

## Timing
- Classification is combinational from `q_in` and `prev`. All effects register on the same rising edge that samples `q_valid`.
- Event latency: sample at edge k makes `evt_valid` high after edge k when the FIFO was empty. Latency is 1 cycle; there is no combinational path from `q_in` to `evt_*`.
- `evt_*` are driven from FIFO registers and hold while `evt_valid & !evt_ready`.
- `locked` rises after the first valid edge following reset release.
- `rst` deassertion is taken synchronously by the design: the first active edge is the one after `rst` goes high.

## Structure
- Shared package `count_mon_pkg`:
  - event code constants `EVT_WRAP`=0, `EVT_RESTART`=1, `EVT_SKIP`=2, `EVT_HOLD`=3;
  - the FSM state encoding;
  - the event record width `2+WIDTH`.
- One sub-module, `evt_fifo`: a parameterised synchronous FIFO with push/pop, full/empty flags, and simultaneous push+pop when full. It shares `clk` and the same async active-low `rst`.
- The top level holds the FSM, `prev`, the classifier, the tallies, and `overflow`.

## Test plan
- Free-running count 0..15, 0..3 with `q_valid`=1 and `evt_ready`=1 → exactly one WRAP, `evt_value`=0, `wrap_count`=1, `err_count`=0, `locked`=1.
- Sequence 5,6,7,0,1 → RESTART with `evt_value`=0; `wrap_count` unchanged.
- Sequence 2,3,9 → SKIP with `evt_value`=9, `err_count`=1; then 10 → no event.
- `evt_ready`=0 while 6 SKIPs occur (DEPTH=4) → 4 entries held, `overflow`=1, `err_count`=6. Then `evt_ready`=1 → 4 pops in order of arrival, and `evt_valid` falls after the 4th.
- `rst` pulsed low mid-count at value 7 → all outputs at reset values during the pulse. After release, samples 0,1 → no event, `locked`=1.
- Full FIFO with push and pop in the same cycle → occupancy stays 4, no drop, `overflow` remains 0. Then force 300 wraps → `wrap_count` saturates at 255.
